muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions. It accepts one operation from the execute stage, runs an iterative shift-add multiply or restoring divide over 32 cycles and returns a 32-bit result. While it works, it holds the pipeline stalled. It sits beside the main ALU in the EX stage and is selected when the decoder flags an M-extension R-type instruction (opcode 0110011, Funct7 = 0000001).

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_datapath.sv | 86 ++++++++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [5:0] ITER_LAST = 6'd31;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// 64-bit accumulator / remainder-quotient register with shared 33-bit adder and final negation.
// Divide stepping and remainder/quotient selection exist only with MULDIV_DIV_EN defined.
module muldiv_datapath
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic        step,
   input  logic        negate,
   input  logic [2:0]  f3,
   input  logic [31:0] init_lo,
   input  logic [31:0] init_opb,
   output logic [31:0] res
);

   logic [63:0] acc;
   logic [31:0] opb;
   logic [32:0] add_a;
   logic [32:0] add_b;
   logic        cin;
   logic [33:0] sum;
   logic [63:0] acc_step;
   logic [63:0] neg64;

   always_comb begin
      add_a = {1'b0, acc[63:32]};
      add_b = {1'b0, opb};
      cin   = 1'b0;
`ifdef MULDIV_DIV_EN
      // Divide: trial-subtract divisor from the shifted 33-bit remainder
      if (f3[2]) begin
         add_a = acc[63:31];
         add_b = ~{1'b0, opb};
         cin   = 1'b1;
      end
`endif
      sum = {1'b0, add_a} + {1'b0, add_b} + {33'b0, cin};
   end

   always_comb begin
      acc_step = acc[0] ? {sum[32:0], acc[31:1]} : {1'b0, acc[63:1]};
`ifdef MULDIV_DIV_EN
      // Carry out of the subtract means the trial remainder is non-negative
      if (f3[2]) begin
         acc_step = sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (load) begin
         acc <= {32'b0, init_lo};
         opb <= init_opb;
      end else if (step) begin
         acc <= acc_step;
      end
   end

   assign neg64 = -acc;

`ifdef MULDIV_DIV_EN
   logic [31:0] neg_hi;
   assign neg_hi = -acc[63:32];

   always_comb begin
      case (f3)
         F3_MUL:                        res = negate ? neg64[31:0]  : acc[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  res = negate ? neg64[63:32] : acc[63:32];
         F3_DIV, F3_DIVU:               res = negate ? neg64[31:0]  : acc[31:0];
         default:                       res = negate ? neg_hi       : acc[63:32];
      endcase
   end
`else
   logic unused_carry;
   assign unused_carry = sum[33];

   always_comb begin
      case (f3)
         F3_MUL:                        res = negate ? neg64[31:0]  : acc[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  res = negate ? neg64[63:32] : acc[63:32];
         default:                       res = '0;
      endcase
   end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, sign flags and pipeline handshake.
// Define MULDIV_DIV_EN for divide/remainder; otherwise Funct3[2] ops finish at once with 0.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        Funct3,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   input  logic              flush,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [DATA_W-1:0] Result
);

   state_t      state;
   logic [5:0]  cnt;
   logic [2:0]  f3_q;
   logic        sgn_q;

   logic        a_signed;
   logic        b_signed;
   logic        sa;
   logic        sb;
   logic        sgn_d;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] init_lo;
   logic [31:0] init_opb;
   logic [31:0] dp_res;
   logic        special;
   logic [31:0] special_res;
   logic        accept;
   logic        load;
   logic        step;

   always_comb begin
      a_signed = Funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
      b_signed = Funct3 inside {F3_MULH, F3_DIV, F3_REM};
      sa       = a_signed & SrcA[31];
      sb       = b_signed & SrcB[31];
      mag_a    = magnitude(SrcA, sa);
      mag_b    = magnitude(SrcB, sb);
      // Remainder takes the dividend's sign; everything else the XOR of both
      sgn_d    = (Funct3[2] & Funct3[1]) ? sa : (sa ^ sb);
      init_lo  = Funct3[2] ? mag_a : mag_b;
      init_opb = Funct3[2] ? mag_b : mag_a;
   end

`ifdef MULDIV_DIV_EN
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (Funct3[2]) begin
         if (SrcB == '0) begin
            special     = 1'b1;
            special_res = Funct3[1] ? SrcA : '1;
         end else if (!Funct3[0] && SrcA == 32'h8000_0000 && SrcB == '1) begin
            special     = 1'b1;
            special_res = Funct3[1] ? 32'h0 : 32'h8000_0000;
         end
      end
   end
`else
   assign special     = Funct3[2];
   assign special_res = '0;
`endif

   assign accept = (state == IDLE) & start & ~flush;
   assign load   = accept & ~special;
   assign step   = (state == CALC) & ~flush;
   assign stall  = busy | (start & (state == IDLE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         f3_q   <= '0;
         sgn_q  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Result <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  f3_q  <= Funct3;
                  sgn_q <= sgn_d;
                  cnt   <= '0;
                  if (special) begin
                     Result <= special_res;
                     state  <= DONE;
                     done   <= 1'b1;
                  end else begin
                     state <= CALC;
                     busy  <= 1'b1;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               if (cnt == ITER_LAST) begin
                  state <= SIGN;
               end
            end
            SIGN: begin
               Result <= dp_res;
               state  <= DONE;
               busy   <= 1'b0;
               done   <= 1'b1;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   muldiv_datapath u_datapath (
      .clk      (clk),
      .load     (load),
      .step     (step),
      .negate   (sgn_q),
      .f3       (f3_q),
      .init_lo  (init_lo),
      .init_opb (init_opb),
      .res      (dp_res)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [2:0]  Funct3;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] Result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .Funct3 (Funct3),
      .SrcA   (SrcA),
      .SrcB   (SrcB),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .Result (Result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Start one op in cycle 0, release start, and time the done pulse.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
      int cyc;
      int stall_bad;
      bit got;
      @(posedge clk); #1;
      start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
      @(negedge clk);
      stall_bad = stall ? 0 : 1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 80) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            check({tag, " stall@done"}, 32'(stall), 32'd0);
         end else begin
            if (!stall) stall_bad++;
            cyc++;
         end
      end
      check({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
      check({tag, " result"}, Result, exp_res);
      check({tag, " stall"}, 32'(stall_bad), 32'd0);
      @(negedge clk);
      check({tag, " pulse"}, 32'(done), 32'd0);
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (done) pulses++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      int n;
      int c1;
      int c2;
      logic sd;

      reset = 1'b1; start = 1'b0; flush = 1'b0;
      Funct3 = '0; SrcA = '0; SrcB = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", Result, 32'h0);
      check("reset stall low", 32'(stall), 32'd0);
      start = 1'b1;
      #1;
      check("reset stall follows start", 32'(stall), 32'd1);
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      run_op("mul 7*-3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("mulh", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

      // Abort a MUL in cycle 10; Result must keep the MULHSU value
      @(posedge clk); #1;
      start = 1'b1; Funct3 = F3_MUL; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush busy before", 32'(busy), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush busy after", 32'(busy), 32'd0);
      check("flush stall after", 32'(stall), 32'd0);
      count_pulses(40, pulses);
      check("flush no done", 32'(pulses), 32'd0);
      check("flush result kept", Result, 32'hFFFF_FFFF);
      run_op("mul after flush", F3_MUL, 32'd3, 32'd4, 32'd12, 34);

      // flush beats start in IDLE
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; Funct3 = F3_MUL; SrcA = 32'd5; SrcB = 32'd5;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush+start busy", 32'(busy), 32'd0);
      count_pulses(40, pulses);
      check("flush+start no done", 32'(pulses), 32'd0);
      check("flush+start result", Result, 32'd12);

      // start held through DONE: second op accepted in cycle 35
      n = 0; c1 = -1; c2 = -1; sd = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; Funct3 = F3_MUL; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge clk);
         if (done) begin
            n++;
            if (n == 1) begin
               c1 = cyc;
               sd = stall;
            end else begin
               c2 = cyc;
            end
         end
         @(posedge clk); #1;
         if (cyc == 35) start = 1'b0;
      end
      check("b2b pulses", 32'(n), 32'd2);
      check("b2b first done", 32'(c1), 32'd34);
      check("b2b second done", 32'(c2), 32'd69);
      check("b2b stall@done", 32'(sd), 32'd0);
      check("b2b result", Result, 32'hFFFF_FFEB);

`ifdef MULDIV_DIV_EN
      run_op("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("divu 100/7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
      run_op("remu 100/7", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
      run_op("div 5/0", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem 5/0", F3_REM, 32'd5, 32'd0, 32'd5, 1);
      run_op("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
`else
      run_op("divu 9/3 off", F3_DIVU, 32'd9, 32'd3, 32'h0, 1);
      run_op("mul 6*7", F3_MUL, 32'd6, 32'd7, 32'd42, 34);
      run_op("div 5/0 off", F3_DIV, 32'd5, 32'd0, 32'h0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
